// File: rtl/input_pair_streamer_if.sv
// RAM read port plus pair stream toward the consumer, bundled for the input pair streamer.
// The master side is the streamer. The slave side is the RAM together with the consumer.
interface input_pair_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] ram_addrs;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_data1;
  logic [DATA_WIDTH-1:0] ram_data2;
  logic [DATA_WIDTH-1:0] out_data1;
  logic [DATA_WIDTH-1:0] out_data2;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ram_addrs, ram_en,
    input  ram_data1, ram_data2,
    output out_data1, out_data2, out_valid,
    input  out_ready
  );

  modport slave (
    input  ram_addrs, ram_en,
    output ram_data1, ram_data2,
    input  out_data1, out_data2, out_valid,
    output out_ready
  );
endinterface

// File: rtl/input_pair_streamer.sv
// Walks the input RAM from a base address and streams (mem[a], mem[a+1]) pairs
// over valid/ready. This block is the only reader of the RAM.
module input_pair_streamer #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STEP       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_pairs,
  input_pair_streamer_if.master bus,
  output logic                  busy,
  output logic                  done
);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load_c, accept_c, ram_en_c;

  // The output slot can take a new pair when it is empty or is being consumed this edge.
  assign load_c   = !valid_q || bus.out_ready;
  assign accept_c = valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (num_pairs == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (load_c && cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (accept_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM data is only captured when the read enable is high, so an undriven RAM bus never reaches the outputs.
  always_comb begin
    ram_en_c = 1'b0;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          cnt_d  = num_pairs;
        end
      end
      ST_FETCH: begin
        ram_en_c = load_c;
        if (load_c) begin
          data1_d = bus.ram_data1;
          data2_d = bus.ram_data2;
          valid_d = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(STEP);
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_DRAIN: if (accept_c) valid_d = 1'b0;
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ram_addrs = addr_q;
  assign bus.ram_en    = ram_en_c;
  assign bus.out_data1 = data1_q;
  assign bus.out_data2 = data2_q;
  assign bus.out_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_input_pair_streamer.sv
// Testbench for input_pair_streamer. Two instances, one with STEP=2 and one with STEP=1, receive the same
// stimulus. The bench predicts their pair and address sequences from the RAM contents.
module tb_input_pair_streamer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] base_addr = '0;
  logic [5:0] num_pairs = '0;
  logic       ready = 1'b1;
  logic       busy2, done2, busy1, done1;
  bit         mon_on = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry holds the STEP=2 expectation in the upper half and the STEP=1 expectation in the lower half.
  logic [63:0] exp_pair[$];
  logic [9:0]  exp_addr[$];

  always #5 clk = ~clk;

  input_pair_streamer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus2 ();
  input_pair_streamer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus1 ();

  input_pair_streamer #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_pairs(num_pairs),
    .bus(bus2), .busy(busy2), .done(done2));

  input_pair_streamer #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_pairs(num_pairs),
    .bus(bus1), .busy(busy1), .done(done1));

  function automatic logic [15:0] mem_word(input int a);
    return 16'(a * 257);
  endfunction

  // Combinational RAM. Its outputs go to high impedance while the read enable is low.
  assign bus2.ram_data1 = bus2.ram_en ? mem_word(int'(bus2.ram_addrs)) : 'z;
  assign bus2.ram_data2 = bus2.ram_en ? mem_word((int'(bus2.ram_addrs) + 1) % 32) : 'z;
  assign bus1.ram_data1 = bus1.ram_en ? mem_word(int'(bus1.ram_addrs)) : 'z;
  assign bus1.ram_data2 = bus1.ram_en ? mem_word((int'(bus1.ram_addrs) + 1) % 32) : 'z;
  assign bus2.out_ready = ready;
  assign bus1.out_ready = ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s2"}, {bus2.out_data1, bus2.out_data2}, 32'h0);
    check({tag, "_s1"}, {bus1.out_data1, bus1.out_data2}, 32'h0);
    check({tag, "_ctl"}, 32'({bus2.ram_addrs, bus2.ram_en, bus2.out_valid, busy2, done2,
                              bus1.ram_addrs, bus1.ram_en, bus1.out_valid, busy1, done1}), 32'h0);
  endtask

  // Scoreboard. It runs on the falling edge, away from the rising edge where the DUTs update.
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (bus2.out_valid || bus1.out_valid) begin
        if (exp_pair.size() == 0) begin
          check("unexpected_pair", 32'h1, 32'h0);
        end else begin
          check("valid_s2", 32'(bus2.out_valid), 32'h1);
          check("valid_s1", 32'(bus1.out_valid), 32'h1);
          check("pair_s2", {bus2.out_data1, bus2.out_data2}, exp_pair[0][63:32]);
          check("pair_s1", {bus1.out_data1, bus1.out_data2}, exp_pair[0][31:0]);
          if (ready) begin
            void'(exp_pair.pop_front());
          end else begin
            check("stall_ram_en_s2", 32'(bus2.ram_en), 32'h0);
            check("stall_ram_en_s1", 32'(bus1.ram_en), 32'h0);
          end
        end
      end
      if (bus2.ram_en || bus1.ram_en) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_read", 32'h1, 32'h0);
        end else begin
          check("ram_addr_s2", {bus2.ram_en, bus2.ram_addrs}, {1'b1, exp_addr[0][9:5]});
          check("ram_addr_s1", {bus1.ram_en, bus1.ram_addrs}, {1'b1, exp_addr[0][4:0]});
          void'(exp_addr.pop_front());
        end
      end
    end
  end

  task automatic load_model(input int base, input int num);
    for (int k = 0; k < num; k++) begin
      int a2, a1;
      a2 = (base + 2 * k) % 32;
      a1 = (base + k) % 32;
      exp_pair.push_back({mem_word(a2), mem_word((a2 + 1) % 32), mem_word(a1), mem_word((a1 + 1) % 32)});
      exp_addr.push_back({5'(a2), 5'(a1)});
    end
  endtask

  task automatic pulse_start(input int base, input int num);
    load_model(base, num);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 5'(base);
    num_pairs = 6'(num);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high. mode 1: ready low for 3 cycles while the second pair is offered. mode 2: random ready.
  // want_cyc gives the number of cycles from the start-sampling edge to done. A negative value skips that check.
  task automatic run(input int base, input int num, input int mode, input bit extra, input int want_cyc);
    int  cyc;
    bit  got_done;
    ready = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
    pulse_start(base, num);
    cyc = 0;
    check("busy_after_start", 32'(busy2 & busy1), 32'h1);
    got_done = done2;
    while (!got_done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (mode != 2 && num > 0 && cyc == 1)
        check("first_valid_latency", 32'(bus2.out_valid & bus1.out_valid), 32'h1);
      start = extra && (cyc == 1);
      if (start) begin
        base_addr = 5'd9;
        num_pairs = 6'd5;
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = !(cyc >= 2 && cyc <= 4);
        default: ready = ($urandom_range(0, 9) < 7);
      endcase
      got_done = done2;
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_timeout", 32'h0, 32'h1);
    end else begin
      if (want_cyc >= 0) check("done_cycle", 32'(cyc), 32'(want_cyc));
      check("done_s1", 32'({done1, busy1, busy2}), 32'h7);
      check("pairs_left", 32'(exp_pair.size()), 32'h0);
      check("reads_left", 32'(exp_addr.size()), 32'h0);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", 32'({done2, done1}), 32'h0);
    check("idle_after_done", 32'({busy2, busy1, bus2.out_valid, bus1.out_valid}), 32'h0);
    exp_pair.delete();
    exp_addr.delete();
  endtask

  initial begin
    #2;
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;

    run(0, 4, 0, 1'b0, 5);
    run(0, 4, 1, 1'b0, 8);
    run(31, 2, 0, 1'b0, 3);
    run(0, 0, 0, 1'b0, 0);
    run(5, 3, 0, 1'b1, 4);
    run(30, 3, 0, 1'b0, 4);
    run(0, 32, 0, 1'b0, 33);

    // An asynchronous reset in the middle of a run clears the outputs with no clock edge.
    pulse_start(3, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_pair.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle_after_reset");
    mon_on = 1'b1;

    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 2, r[0], -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
